// File: rtl/phase_increment_bank.sv
// Multi-channel frequency-to-phase-increment converter: one shared LSB-first
// shift-add multiplier fills per-channel targets; live increments track or slew toward them.
module phase_increment_bank #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned FREQ_W    = 32,
    parameter int unsigned INC_W     = 32,
    parameter int unsigned K_W       = 32,
    parameter logic [K_W-1:0] K_CONST = 32'd22906492,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic                      Sys_clk,
    input  logic                      Inc_rst,
    input  logic                      Inc_ce,
    input  logic                      Freq_wr,
    input  logic [CH_W-1:0]           Freq_ch,
    input  logic [FREQ_W-1:0]         Freq,
    output logic                      Freq_ack,
    output logic                      Busy,
    input  logic                      Glide_en,
    input  logic                      Glide_tick,
    input  logic [INC_W-1:0]          Glide_step,
    output logic                      Inc_valid,
    output logic [CH_W-1:0]           Inc_ch,
    output logic [CHANNELS*INC_W-1:0] Sin_inc
);

    localparam int unsigned PROD_W = FREQ_W + K_W;
    localparam int unsigned CNT_W  = $clog2(FREQ_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FREQ_W - 1);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [FREQ_W-1:0]   freq_r;
    logic [PROD_W-1:0]   mcand_r;
    logic [PROD_W-1:0]   prod_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CH_W-1:0]     ch_r;
    logic                busy_r;
    logic                ack_r;
    logic                valid_r;
    logic [CH_W-1:0]     inc_ch_r;
    logic [INC_W-1:0]    target_r [CHANNELS];
    logic [INC_W-1:0]    cur_r    [CHANNELS];

    function automatic logic [INC_W-1:0] saturate(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] s;
        s = p >> FRAC_BITS;
        if (|s[PROD_W-1:INC_W]) begin
            saturate = {INC_W{1'b1}};
        end else begin
            saturate = s[INC_W-1:0];
        end
    endfunction

    // Move cur toward tgt by at most step; lands exactly on tgt when within reach.
    function automatic logic [INC_W-1:0] glide_next(input logic [INC_W-1:0] cur,
                                                    input logic [INC_W-1:0] tgt,
                                                    input logic [INC_W-1:0] step);
        if (tgt >= cur) begin
            glide_next = ((tgt - cur) <= step) ? tgt : cur + step;
        end else begin
            glide_next = ((cur - tgt) <= step) ? tgt : cur - step;
        end
    endfunction

    // Conversion FSM: accept write, shift-add multiply, commit target
    always_ff @(posedge Sys_clk) begin
        if (Inc_rst) begin
            state_r  <= IDLE;
            freq_r   <= '0;
            mcand_r  <= '0;
            prod_r   <= '0;
            cnt_r    <= '0;
            ch_r     <= '0;
            busy_r   <= 1'b0;
            ack_r    <= 1'b0;
            valid_r  <= 1'b0;
            inc_ch_r <= '0;
            for (int n = 0; n < CHANNELS; n++) target_r[n] <= '0;
        end else begin
            ack_r   <= 1'b0;
            valid_r <= 1'b0;
            if (Inc_ce) begin
                case (state_r)
                    IDLE: begin
                        if (Freq_wr) begin
                            freq_r  <= Freq;
                            ch_r    <= Freq_ch;
                            prod_r  <= '0;
                            mcand_r <= {{FREQ_W{1'b0}}, K_CONST};
                            cnt_r   <= '0;
                            ack_r   <= 1'b1;
                            busy_r  <= 1'b1;
                            state_r <= MUL;
                        end
                    end
                    MUL: begin
                        if (freq_r[0]) prod_r <= prod_r + mcand_r;
                        mcand_r <= mcand_r << 1;
                        freq_r  <= freq_r >> 1;
                        if (cnt_r == LAST_BIT) begin
                            state_r <= DONE;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                    DONE: begin
                        // Out-of-range channels complete silently
                        if ({1'b0, ch_r} < CH_LIMIT) begin
                            target_r[ch_r] <= saturate(prod_r);
                            valid_r        <= 1'b1;
                            inc_ch_r       <= ch_r;
                        end
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    // Live increments: follow targets directly, or slew on each glide tick
    always_ff @(posedge Sys_clk) begin
        if (Inc_rst) begin
            for (int n = 0; n < CHANNELS; n++) cur_r[n] <= '0;
        end else if (Inc_ce) begin
            if (!Glide_en) begin
                for (int n = 0; n < CHANNELS; n++) cur_r[n] <= target_r[n];
            end else if (Glide_tick) begin
                for (int n = 0; n < CHANNELS; n++)
                    cur_r[n] <= glide_next(cur_r[n], target_r[n], Glide_step);
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign Sin_inc[g*INC_W +: INC_W] = cur_r[g];
    end

    assign Freq_ack  = ack_r;
    assign Busy      = busy_r;
    assign Inc_valid = valid_r;
    assign Inc_ch    = inc_ch_r;

endmodule

// File: tb/tb_phase_increment_bank.sv
// Randomized scoreboard bench for phase_increment_bank: expected increments
// come from plain 64-bit arithmetic; a monitor pops them on each Inc_valid.
module tb_phase_increment_bank;

    localparam int K = 22906492;

    logic         Sys_clk = 1'b0;
    logic         Inc_rst, Inc_ce, Freq_wr, Glide_en, Glide_tick;
    logic [1:0]   Freq_ch;
    logic [31:0]  Freq, Glide_step;
    logic         Freq_ack, Busy, Inc_valid;
    logic [1:0]   Inc_ch;
    logic [127:0] Sin_inc;

    phase_increment_bank dut (
        .Sys_clk(Sys_clk), .Inc_rst(Inc_rst), .Inc_ce(Inc_ce),
        .Freq_wr(Freq_wr), .Freq_ch(Freq_ch), .Freq(Freq),
        .Freq_ack(Freq_ack), .Busy(Busy),
        .Glide_en(Glide_en), .Glide_tick(Glide_tick), .Glide_step(Glide_step),
        .Inc_valid(Inc_valid), .Inc_ch(Inc_ch), .Sin_inc(Sin_inc)
    );

    always #5 Sys_clk = ~Sys_clk;

    typedef struct {
        int          ch;
        logic [31:0] val;
        int unsigned due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_tgt [4];
    logic [31:0] model_cur [4];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          pend = 1'b0;
    int          pend_ch;
    logic [31:0] pend_val;

    always @(posedge Sys_clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_inc(input logic [31:0] f);
        longint unsigned p;
        p = (longint'(f) * longint'(K)) >> 8;
        return (p > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
    endfunction

    function automatic logic [31:0] ref_glide(input logic [31:0] cur, input logic [31:0] tgt,
                                              input logic [31:0] step);
        longint d;
        d = longint'(tgt) - longint'(cur);
        if (d < 0) d = -d;
        if (d <= longint'(step)) return tgt;
        return (tgt > cur) ? cur + step : cur - step;
    endfunction

    function automatic logic [31:0] chan(input int n);
        return Sin_inc[n*32 +: 32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pop the scoreboard on each Inc_valid; verify the output one cycle later
    always @(negedge Sys_clk) begin
        if (Inc_rst) begin
            for (int n = 0; n < 4; n++) model_tgt[n] = 32'd0;
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (!Glide_en) check($sformatf("sin_inc_ch%0d", pend_ch), 64'(chan(pend_ch)), 64'(pend_val));
                pend = 1'b0;
            end
            if (Inc_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_inc_valid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("inc_ch", 64'(Inc_ch), 64'(e.ch));
                    check("valid_cycle", 64'(cyc), 64'(e.due));
                    model_tgt[e.ch] = e.val;
                    pend_ch = e.ch;
                    pend_val = e.val;
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic do_write(input int ch, input logic [31:0] f, output bit acked);
        Freq_wr = 1'b1;
        Freq_ch = 2'(ch);
        Freq    = f;
        tick();
        Freq_wr = 1'b0;
        acked   = Freq_ack;
    endtask

    task automatic write_expect(input int ch, input logic [31:0] f, input int extra);
        bit          a;
        int unsigned k;
        exp_t        e;
        k = cyc;
        do_write(ch, f, a);
        check("freq_ack", 64'(a), 64'd1);
        e.ch = ch; e.val = ref_inc(f); e.due = k + 34 + extra;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 120) begin
            tick();
            n++;
        end
        if (n >= 120) check("inc_valid_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic check_all(input string name);
        for (int n = 0; n < 4; n++) check($sformatf("%s_ch%0d", name, n), 64'(chan(n)), 64'(model_cur[n]));
    endtask

    task automatic glide_tick_step(input logic [31:0] step);
        Glide_step = step;
        Glide_tick = 1'b1;
        for (int n = 0; n < 4; n++) model_cur[n] = ref_glide(model_cur[n], model_tgt[n], step);
        tick();
        Glide_tick = 1'b0;
    endtask

    initial begin
        bit          a;
        int unsigned k;
        logic [31:0] f;
        exp_t        e;
        Inc_rst = 1'b1; Inc_ce = 1'b1; Freq_wr = 1'b0; Freq_ch = 2'd0; Freq = 32'd0;
        Glide_en = 1'b0; Glide_tick = 1'b0; Glide_step = 32'd0;
        repeat (3) tick();
        check("rst_sin_inc", 64'(Sin_inc != 128'd0), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_ack", 64'(Freq_ack), 64'd0);
        check("rst_valid", 64'(Inc_valid), 64'd0);
        check("rst_inc_ch", 64'(Inc_ch), 64'd0);
        Inc_rst = 1'b0;
        tick();

        // Single write, fixed latency
        write_expect(0, 32'd440, 0);
        check("busy_after_ack", 64'(Busy), 64'd1);
        wait_idle();
        check("t1_ch0", 64'(chan(0)), 64'd39370533);

        // Second write while busy is refused until the first completes
        k = cyc;
        write_expect(1, 32'd880, 0);
        for (int i = 0; i < 40; i++) begin
            int unsigned c;
            c = cyc;
            do_write(2, 32'd1000, a);
            check("retry_ack", 64'(a), 64'(c + 1 >= k + 35));
            if (c + 1 >= k + 35) begin
                e.ch = 2; e.val = ref_inc(32'd1000); e.due = c + 34;
                sb_q.push_back(e);
                break;
            end
        end
        wait_idle();
        check("t2_ch1", 64'(chan(1)), 64'd78741066);
        check("t2_ch2", 64'(chan(2)), 64'd89478484);
        check("t2_ch0", 64'(chan(0)), 64'd39370533);

        // Saturation and zero
        write_expect(3, 32'hFFFF_FFFF, 0);
        wait_idle();
        check("sat_ch3", 64'(chan(3)), 64'hFFFF_FFFF);
        write_expect(3, 32'd0, 0);
        wait_idle();
        check("zero_ch3", 64'(chan(3)), 64'd0);

        // Random conversions with outputs tracking targets
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: f = $urandom();
                1: f = $urandom_range(20, 20000);
                2: f = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: f = $urandom_range(0, 200000000);
            endcase
            write_expect(int'($urandom_range(0, 3)), f, 0);
            wait_idle();
        end
        for (int n = 0; n < 4; n++) model_cur[n] = model_tgt[n];
        check_all("rand");

        // Glide from 0 toward 1000 Hz on ch0
        write_expect(0, 32'd0, 0);
        wait_idle();
        Glide_en = 1'b1;
        write_expect(0, 32'd1000, 0);
        wait_idle();
        for (int n = 0; n < 4; n++) model_cur[n] = (n == 0) ? 32'd0 : model_tgt[n];
        check("glide_hold_ch0", 64'(chan(0)), 64'd0);
        glide_tick_step(32'd30000000);
        check("glide1_ch0", 64'(chan(0)), 64'd30000000);
        repeat (3) tick();
        glide_tick_step(32'd30000000);
        check("glide2_ch0", 64'(chan(0)), 64'd60000000);
        repeat (3) tick();
        glide_tick_step(32'd30000000);
        check("glide3_ch0", 64'(chan(0)), 64'd89478484);
        repeat (3) tick();
        glide_tick_step(32'd30000000);
        check_all("glide_settled");

        // Random targets slewed with random steps
        for (int n = 0; n < 4; n++) begin
            write_expect(n, $urandom_range(0, 30000), 0);
            wait_idle();
        end
        check_all("glide_no_tick");
        for (int i = 0; i < 10; i++) begin
            glide_tick_step((i % 4 == 3) ? 32'd0 : $urandom_range(1, 1 << 26));
            check_all("glide_rand");
            repeat ($urandom_range(0, 3)) tick();
        end
        Glide_en = 1'b0;
        tick();
        for (int n = 0; n < 4; n++) model_cur[n] = model_tgt[n];
        check_all("glide_snap");

        // Clock-enable stall mid-multiply
        write_expect(0, 32'd440, 10);
        repeat (5) tick();
        Inc_ce = 1'b0;
        repeat (10) tick();
        Inc_ce = 1'b1;
        wait_idle();
        check("ce_ch0", 64'(chan(0)), 64'd39370533);

        // Reset aborts a conversion in flight
        do_write(1, 32'd12345, a);
        check("pre_rst_ack", 64'(a), 64'd1);
        repeat (10) tick();
        Inc_rst = 1'b1;
        tick();
        Inc_rst = 1'b0;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_sin_inc", 64'(Sin_inc != 128'd0), 64'd0);
        repeat (40) tick();
        check("abort_no_valid_sin", 64'(Sin_inc != 128'd0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
